// File: rtl/pool_pkg.sv
// Shared constants for the pooling path: data width, window geometry,
// reader FSM encodings and the output-dimension derivation.
package pool_pkg;

    localparam int DATA_W   = 23;
    localparam int WIN      = 3;
    localparam int STRIDE   = 2;
    localparam int IN_DIM   = 55;
    localparam int CHANNELS = 96;
    localparam int ADDR_W   = 19;

    // Number of window positions along one axis of a plane.
    function automatic int out_dim(input int in_dim, input int stride);
        return (in_dim - WIN) / stride + 1;
    endfunction

    localparam int OUT_DIM = out_dim(IN_DIM, STRIDE);

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_FETCH = 3'd1;
    localparam state_t ST_WAIT  = 3'd2;
    localparam state_t ST_EMIT  = 3'd3;
    localparam state_t ST_FIN   = 3'd4;

endpackage

// File: rtl/pool_addr_gen.sv
// Walks channel / window-row / window-column / tap and produces the buffer
// read address using only incremental adders on base registers.
module pool_addr_gen
    import pool_pkg::*;
#(
    parameter int IN_DIM   = pool_pkg::IN_DIM,
    parameter int STRIDE   = pool_pkg::STRIDE,
    parameter int OUT_DIM  = pool_pkg::OUT_DIM,
    parameter int CHANNELS = pool_pkg::CHANNELS,
    parameter int ADDR_W   = pool_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              advance_k,
    input  logic              advance_win,
    output logic              last_k,
    output logic              last_win,
    output logic [ADDR_W-1:0] rd_addr
);

    localparam int C_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int OD_W = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;

    localparam logic [ADDR_W-1:0] STEP_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] STEP_COL   = ADDR_W'(STRIDE);
    localparam logic [ADDR_W-1:0] STEP_TAP   = ADDR_W'(IN_DIM);
    localparam logic [ADDR_W-1:0] STEP_ROW   = ADDR_W'(STRIDE * IN_DIM);
    localparam logic [ADDR_W-1:0] STEP_PLANE = ADDR_W'(IN_DIM * IN_DIM);

    logic [C_W-1:0]    c_r;
    logic [OD_W-1:0]   oy_r;
    logic [OD_W-1:0]   ox_r;
    logic [1:0]        ky_r;
    logic [1:0]        kx_r;
    logic [ADDR_W-1:0] plane_base_r;
    logic [ADDR_W-1:0] row_base_r;
    logic [ADDR_W-1:0] win_base_r;
    logic [ADDR_W-1:0] tap_row_r;
    logic [ADDR_W-1:0] addr_r;

    logic c_last_s;
    logic oy_last_s;
    logic ox_last_s;
    logic [ADDR_W-1:0] plane_next_s;
    logic [ADDR_W-1:0] row_next_s;
    logic [ADDR_W-1:0] col_next_s;

    // Wrap detection and the three candidate window bases.
    always_comb begin
        c_last_s     = (c_r == C_W'(CHANNELS - 1));
        oy_last_s    = (oy_r == OD_W'(OUT_DIM - 1));
        ox_last_s    = (ox_r == OD_W'(OUT_DIM - 1));
        plane_next_s = plane_base_r + STEP_PLANE;
        row_next_s   = row_base_r + STEP_ROW;
        col_next_s   = win_base_r + STEP_COL;
    end

    // Counters and base registers; addr_r always holds the address of the current tap.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            c_r          <= '0;
            oy_r         <= '0;
            ox_r         <= '0;
            ky_r         <= 2'd0;
            kx_r         <= 2'd0;
            plane_base_r <= '0;
            row_base_r   <= '0;
            win_base_r   <= '0;
            tap_row_r    <= '0;
            addr_r       <= '0;
        end else if (advance_win) begin
            ky_r <= 2'd0;
            kx_r <= 2'd0;
            if (ox_last_s) begin
                ox_r <= '0;
                if (oy_last_s) begin
                    oy_r         <= '0;
                    c_r          <= c_last_s ? '0 : c_r + C_W'(1);
                    plane_base_r <= plane_next_s;
                    row_base_r   <= plane_next_s;
                    win_base_r   <= plane_next_s;
                    tap_row_r    <= plane_next_s;
                    addr_r       <= plane_next_s;
                end else begin
                    oy_r       <= oy_r + OD_W'(1);
                    row_base_r <= row_next_s;
                    win_base_r <= row_next_s;
                    tap_row_r  <= row_next_s;
                    addr_r     <= row_next_s;
                end
            end else begin
                ox_r       <= ox_r + OD_W'(1);
                win_base_r <= col_next_s;
                tap_row_r  <= col_next_s;
                addr_r     <= col_next_s;
            end
        end else if (advance_k) begin
            if (kx_r == 2'd2) begin
                kx_r <= 2'd0;
                if (ky_r == 2'd2) begin
                    ky_r      <= 2'd0;
                    tap_row_r <= win_base_r;
                    addr_r    <= win_base_r;
                end else begin
                    ky_r      <= ky_r + 2'd1;
                    tap_row_r <= tap_row_r + STEP_TAP;
                    addr_r    <= tap_row_r + STEP_TAP;
                end
            end else begin
                kx_r   <= kx_r + 2'd1;
                addr_r <= addr_r + STEP_ONE;
            end
        end else begin
            addr_r <= addr_r;
        end
    end

    assign last_k   = (ky_r == 2'd2) && (kx_r == 2'd2);
    assign last_win = c_last_s && oy_last_s && ox_last_s;
    assign rd_addr  = addr_r;

endmodule

// File: rtl/pool_window_reader.sv
// Reads 3x3 pooling windows channel by channel from the activation buffer
// and presents each one on num1..num9 with a single-cycle en strobe.
module pool_window_reader
    import pool_pkg::*;
#(
    parameter int DATA_W   = pool_pkg::DATA_W,
    parameter int IN_DIM   = pool_pkg::IN_DIM,
    parameter int STRIDE   = pool_pkg::STRIDE,
    parameter int OUT_DIM  = pool_pkg::out_dim(IN_DIM, STRIDE),
    parameter int CHANNELS = pool_pkg::CHANNELS,
    parameter int ADDR_W   = pool_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] num1,
    output logic [DATA_W-1:0] num2,
    output logic [DATA_W-1:0] num3,
    output logic [DATA_W-1:0] num4,
    output logic [DATA_W-1:0] num5,
    output logic [DATA_W-1:0] num6,
    output logic [DATA_W-1:0] num7,
    output logic [DATA_W-1:0] num8,
    output logic [DATA_W-1:0] num9,
    output logic              en
);

    state_t state_r;
    state_t state_nxt;

    logic busy_nxt;
    logic done_nxt;
    logic rd_en_nxt;
    logic en_nxt;
    logic busy_r;
    logic done_r;
    logic rd_en_r;
    logic en_r;
    logic rd_valid_r;

    logic clear_s;
    logic advance_k_s;
    logic advance_win_s;
    logic last_k_s;
    logic last_win_s;

    assign clear_s       = (state_r == ST_IDLE) && start;
    assign advance_k_s   = (state_r == ST_FETCH);
    assign advance_win_s = (state_r == ST_EMIT);

    pool_addr_gen #(
        .IN_DIM   (IN_DIM),
        .STRIDE   (STRIDE),
        .OUT_DIM  (OUT_DIM),
        .CHANNELS (CHANNELS),
        .ADDR_W   (ADDR_W)
    ) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear_s),
        .advance_k   (advance_k_s),
        .advance_win (advance_win_s),
        .last_k      (last_k_s),
        .last_win    (last_win_s),
        .rd_addr     (rd_addr)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            ST_IDLE:  state_nxt = start ? ST_FETCH : ST_IDLE;
            ST_FETCH: state_nxt = last_k_s ? ST_WAIT : ST_FETCH;
            ST_WAIT:  state_nxt = ST_EMIT;
            ST_EMIT:  state_nxt = last_win_s ? ST_FIN : ST_FETCH;
            ST_FIN:   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state so the strobes leave a flop.
    always_comb begin
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        rd_en_nxt = 1'b0;
        en_nxt    = 1'b0;
        case (state_nxt)
            ST_IDLE:  busy_nxt = 1'b0;
            ST_FETCH: begin
                busy_nxt  = 1'b1;
                rd_en_nxt = 1'b1;
            end
            ST_WAIT:  busy_nxt = 1'b1;
            ST_EMIT: begin
                busy_nxt = 1'b1;
                en_nxt   = 1'b1;
            end
            ST_FIN:   done_nxt = 1'b1;
            default:  busy_nxt = 1'b0;
        endcase
    end

    // Output registers; rd_valid_r marks the cycle the buffer answers a read.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            rd_en_r    <= 1'b0;
            en_r       <= 1'b0;
            rd_valid_r <= 1'b0;
        end else begin
            busy_r     <= busy_nxt;
            done_r     <= done_nxt;
            rd_en_r    <= rd_en_nxt;
            en_r       <= en_nxt;
            rd_valid_r <= rd_en_r;
        end
    end

    // Reads return in tap order, so a nine-deep shift leaves tap 0 in num1.
    always_ff @(posedge clk) begin
        if (rst) begin
            num1 <= '0;
            num2 <= '0;
            num3 <= '0;
            num4 <= '0;
            num5 <= '0;
            num6 <= '0;
            num7 <= '0;
            num8 <= '0;
            num9 <= '0;
        end else if (rd_valid_r) begin
            num1 <= num2;
            num2 <= num3;
            num3 <= num4;
            num4 <= num5;
            num5 <= num6;
            num6 <= num7;
            num7 <= num8;
            num8 <= num9;
            num9 <= rd_data;
        end else begin
            num1 <= num1;
        end
    end

    assign busy  = busy_r;
    assign done  = done_r;
    assign rd_en = rd_en_r;
    assign en    = en_r;

endmodule

// File: tb/tb_pool_window_reader.sv
// Directed bench for pool_window_reader on a 5x5 map (1 and 2 channels)
// with a buffer model that returns its own address as data.
module tb_pool_window_reader;

    localparam int DW = 23;
    localparam int AW = 19;

    typedef logic [8:0][DW-1:0] win_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start1 = 1'b0;
    logic start2 = 1'b0;

    logic          busy1, done1, rd_en1, en1;
    logic [AW-1:0] rd_addr1;
    logic [DW-1:0] rd_data1 = '0;
    logic [DW-1:0] a1, a2, a3, a4, a5, a6, a7, a8, a9;
    logic          busy2, done2, rd_en2, en2;
    logic [AW-1:0] rd_addr2;
    logic [DW-1:0] rd_data2 = '0;
    logic [DW-1:0] b1, b2, b3, b4, b5, b6, b7, b8, b9;

    int n_cmp = 0;
    int n_mis = 0;
    int edge_cnt = 0;
    int s_edge = 0;

    int   en_q1[$];
    int   done_q1[$];
    logic done_busy_q1[$];
    win_t win_q1[$];
    int   en_q2[$];
    int   done_q2[$];
    win_t win_q2[$];

    int exp_first[9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
    int exp_last[9]  = '{12, 13, 14, 17, 18, 19, 22, 23, 24};
    int exp_en[4]    = '{11, 22, 33, 44};
    int exp_base[4]  = '{0, 2, 10, 12};
    int exp_max[4]   = '{12, 14, 22, 24};

    always #5 clk = ~clk;

    pool_window_reader #(
        .DATA_W(DW), .IN_DIM(5), .STRIDE(2), .OUT_DIM(2), .CHANNELS(1), .ADDR_W(AW)
    ) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
        .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1),
        .num1(a1), .num2(a2), .num3(a3), .num4(a4), .num5(a5),
        .num6(a6), .num7(a7), .num8(a8), .num9(a9), .en(en1)
    );

    pool_window_reader #(
        .DATA_W(DW), .IN_DIM(5), .STRIDE(2), .OUT_DIM(2), .CHANNELS(2), .ADDR_W(AW)
    ) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
        .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_data(rd_data2),
        .num1(b1), .num2(b2), .num3(b3), .num4(b4), .num5(b5),
        .num6(b6), .num7(b7), .num8(b8), .num9(b9), .en(en2)
    );

    // Buffer model: one-cycle read latency, data equals address.
    always @(posedge clk) begin
        edge_cnt <= edge_cnt + 1;
        if (rd_en1) rd_data1 <= DW'(rd_addr1);
        if (rd_en2) rd_data2 <= DW'(rd_addr2);
    end

    // An output seen between edges N-1 and N is logged as cycle N relative to start.
    always @(negedge clk) begin
        int   lbl;
        win_t w;
        lbl = edge_cnt - s_edge + 1;
        if (en1) begin
            w = {a9, a8, a7, a6, a5, a4, a3, a2, a1};
            en_q1.push_back(lbl);
            win_q1.push_back(w);
        end
        if (done1) begin
            done_q1.push_back(lbl);
            done_busy_q1.push_back(busy1);
        end
        if (en2) begin
            w = {b9, b8, b7, b6, b5, b4, b3, b2, b1};
            en_q2.push_back(lbl);
            win_q2.push_back(w);
        end
        if (done2) done_q2.push_back(lbl);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_mis++;
            $display("FAIL %s: got %0d, want %0d", tag, got, want);
        end
    endtask

    function automatic int win_max(input win_t w);
        int m;
        m = 0;
        for (int i = 0; i < 9; i++) if (int'(w[i]) > m) m = int'(w[i]);
        return m;
    endfunction

    task automatic do_start(input int which);
        @(negedge clk);
        if (which == 1) start1 = 1'b1; else start2 = 1'b1;
        @(posedge clk);
        #1;
        s_edge = edge_cnt;
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic clear_logs();
        en_q1.delete(); done_q1.delete(); done_busy_q1.delete(); win_q1.delete();
        en_q2.delete(); done_q2.delete(); win_q2.delete();
    endtask

    initial begin
        win_t w;
        int   sz;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_busy", 32'(busy1), 32'd0);
        check_eq("rst_done", 32'(done1), 32'd0);
        check_eq("rst_rd_en", 32'(rd_en1), 32'd0);
        check_eq("rst_rd_addr", 32'(rd_addr1), 32'd0);
        check_eq("rst_en", 32'(en1), 32'd0);
        check_eq("rst_num1", 32'(a1), 32'd0);
        check_eq("rst_num9", 32'(b9), 32'd0);

        // One channel, all four windows, with a stray start while busy.
        clear_logs();
        do_start(1);
        @(negedge clk);
        check_eq("busy_c1", 32'(busy1), 32'd1);
        check_eq("rd_en_c1", 32'(rd_en1), 32'd1);
        check_eq("rd_addr_k0", 32'(rd_addr1), 32'd0);
        @(negedge clk);
        check_eq("rd_addr_k1", 32'(rd_addr1), 32'd1);
        @(negedge clk);
        @(negedge clk);
        check_eq("rd_addr_k3", 32'(rd_addr1), 32'd5);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (55) @(negedge clk);

        check_eq("en_count", 32'(en_q1.size()), 32'd4);
        sz = en_q1.size();
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("en_cycle%0d", i), (i < sz) ? 32'(en_q1[i]) : 32'hFFFF_FFFF,
                     32'(exp_en[i]));
            w = (i < sz) ? win_q1[i] : '1;
            check_eq($sformatf("win%0d_base", i), 32'(w[0]), 32'(exp_base[i]));
            check_eq($sformatf("maxpool_out%0d", i), 32'(win_max(w)), 32'(exp_max[i]));
        end
        w = (sz > 0) ? win_q1[0] : '1;
        for (int j = 0; j < 9; j++) check_eq($sformatf("first_num%0d", j + 1), 32'(w[j]), 32'(exp_first[j]));
        w = (sz > 3) ? win_q1[3] : '1;
        for (int j = 0; j < 9; j++) check_eq($sformatf("last_num%0d", j + 1), 32'(w[j]), 32'(exp_last[j]));
        check_eq("done_count", 32'(done_q1.size()), 32'd1);
        check_eq("done_cycle", (done_q1.size() > 0) ? 32'(done_q1[0]) : 32'hFFFF_FFFF, 32'd45);
        check_eq("busy_at_done", (done_busy_q1.size() > 0) ? 32'(done_busy_q1[0]) : 32'd1, 32'd0);

        // Reset in the middle of the second window's fetch.
        clear_logs();
        do_start(1);
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst_busy", 32'(busy1), 32'd0);
        check_eq("midrst_rd_en", 32'(rd_en1), 32'd0);
        check_eq("midrst_en", 32'(en1), 32'd0);
        check_eq("midrst_num", 32'({a1, a2, a3, a4, a5, a6, a7, a8, a9} != '0), 32'd0);
        repeat (40) @(negedge clk);
        check_eq("midrst_done_count", 32'(done_q1.size()), 32'd0);
        check_eq("midrst_en_count", 32'(en_q1.size()), 32'd1);
        check_eq("midrst_idle_num9", 32'(a9), 32'd0);

        clear_logs();
        do_start(1);
        repeat (15) @(negedge clk);
        check_eq("restart_en_count", 32'(en_q1.size()), 32'd1);
        check_eq("restart_en_cycle", (en_q1.size() > 0) ? 32'(en_q1[0]) : 32'hFFFF_FFFF, 32'd11);
        w = (win_q1.size() > 0) ? win_q1[0] : '1;
        check_eq("restart_num1", 32'(w[0]), 32'd0);
        check_eq("restart_num5", 32'(w[4]), 32'd6);
        check_eq("restart_num9", 32'(w[8]), 32'd12);
        repeat (40) @(negedge clk);

        // Two channels.
        clear_logs();
        do_start(2);
        repeat (100) @(negedge clk);
        check_eq("ch2_en_count", 32'(en_q2.size()), 32'd8);
        check_eq("ch2_en8_cycle", (en_q2.size() > 7) ? 32'(en_q2[7]) : 32'hFFFF_FFFF, 32'd88);
        w = (win_q2.size() > 4) ? win_q2[4] : '1;
        check_eq("ch2_win5_num1", 32'(w[0]), 32'd25);
        check_eq("ch2_win5_num9", 32'(w[8]), 32'd37);
        w = (win_q2.size() > 7) ? win_q2[7] : '1;
        check_eq("ch2_win8_num1", 32'(w[0]), 32'd37);
        check_eq("ch2_win8_num9", 32'(w[8]), 32'd49);
        check_eq("ch2_done_count", 32'(done_q2.size()), 32'd1);
        check_eq("ch2_done_cycle", (done_q2.size() > 0) ? 32'(done_q2[0]) : 32'hFFFF_FFFF, 32'd89);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
